// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM fetch arbiter.
// Owners are one bit: instruction fetch (I) and data load (D).
package rom_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int MAX_READ_LATENCY = 4;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/rom_rsp_tag_pipe.sv
// Shift register of {valid, owner} tags that mirrors the ROM read latency.
// The tag leaving the last stage names the owner of the current rom_douta word.
module rom_rsp_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clka,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out
);

  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  tag_t [LAT-1:0] stage_q;
  tag_t [LAT-1:0] stage_d;

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: every stage is cleared on reset, because a stale valid bit here would
  // emit a response for a request issued before reset.
  always_ff @(posedge clka) begin
    if (clr) begin
      stage_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so all stages shift on the same edge.
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin share of one synchronous-read ROM between instruction fetch (I)
// and data load (D); each returned word is routed back to the requester that issued it.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              rom_ena,
  output logic [ADDR_W-1:0] rom_addra,
  input  logic [DATA_W-1:0] rom_douta,
  output logic              misalign_err
);

  logic              last_grant_q, last_grant_d;
  logic              misalign_q, misalign_d;
  logic              grant;
  logic              owner;
  logic [ADDR_W-1:0] sel_addr;
  tag_t              rsp_tag;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant        = 1'b0;
    owner        = OWNER_I;
    if (!rsta) begin
      if (i_req_valid && d_req_valid) begin
        grant = 1'b1;
        owner = ~last_grant_q;
      end else if (i_req_valid) begin
        grant = 1'b1;
        owner = OWNER_I;
      end else if (d_req_valid) begin
        grant = 1'b1;
        owner = OWNER_D;
      end
    end

    sel_addr     = (owner == OWNER_D) ? d_req_addr : i_req_addr;
    i_req_ready  = grant && (owner == OWNER_I);
    d_req_ready  = grant && (owner == OWNER_D);
    rom_ena      = grant;
    rom_addra    = grant ? {sel_addr[ADDR_W-1:2], 2'b00} : '0;
    last_grant_d = grant ? owner : last_grant_q;
    misalign_d   = misalign_q | (grant && (sel_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      last_grant_q <= OWNER_D;
      misalign_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      misalign_q   <= misalign_d;
    end
  end

  rom_rsp_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clka   (clka),
    .clr    (rsta),
    .tag_in ('{valid: grant, owner: owner}),
    .tag_out(rsp_tag)
  );

  // Responses are masked during reset since the pipe only clears at the edge.
  always_comb begin
    i_rsp_valid = !rsta && rsp_tag.valid && (rsp_tag.owner == OWNER_I);
    d_rsp_valid = !rsta && rsp_tag.valid && (rsp_tag.owner == OWNER_D);
    i_rsp_data  = i_rsp_valid ? rom_douta : '0;
    d_rsp_data  = d_rsp_valid ? rom_douta : '0;
  end

  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: one instance at READ_LATENCY=1 and one at 3 share stimulus;
// a queue-based model predicts every output each cycle, plus directed literal checks.
module tb_rom_fetch_arbiter;

  logic        clka = 1'b0;
  logic        rsta;
  logic        i_req_valid, d_req_valid;
  logic [31:0] i_req_addr, d_req_addr;

  logic        i_rdy1, d_rdy1, i_rv1, d_rv1, ena1, mis1;
  logic [31:0] i_rd1, d_rd1, addra1, douta1;
  logic        i_rdy3, d_rdy3, i_rv3, d_rv3, ena3, mis3;
  logic [31:0] i_rd3, d_rd3, addra3, douta3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clka = ~clka;

  rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut1 (
    .clka(clka), .rsta(rsta),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_rdy1),
    .i_rsp_valid(i_rv1), .i_rsp_data(i_rd1),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_rdy1),
    .d_rsp_valid(d_rv1), .d_rsp_data(d_rd1),
    .rom_ena(ena1), .rom_addra(addra1), .rom_douta(douta1), .misalign_err(mis1)
  );

  rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clka(clka), .rsta(rsta),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_rdy3),
    .i_rsp_valid(i_rv3), .i_rsp_data(i_rd3),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_rdy3),
    .d_rsp_valid(d_rv3), .d_rsp_data(d_rd3),
    .rom_ena(ena3), .rom_addra(addra3), .rom_douta(douta3), .misalign_err(mis3)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA500_0000 | {24'h0, a[9:2]};
  endfunction

  // ROM models: word n = A500_0000|n, output valid READ_LATENCY edges after sampling.
  logic [31:0] r1;
  logic [31:0] r3 [3];
  always @(posedge clka) begin
    r1    <= rom_word(addra1);
    r3[0] <= rom_word(addra3);
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign douta1 = r1;
  assign douta3 = r3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   cyc    = 0;
  bit   m_live = 0;
  logic m_last = 1'b1;
  logic m_mis  = 1'b0;
  bit   m_i_acc = 0;
  bit   m_d_acc = 0;

  task automatic cmp_dut(input string s,
                         input logic ir, input logic dr, input logic en, input logic [31:0] ad,
                         input logic iv, input logic [31:0] id, input logic dv, input logic [31:0] dd,
                         input logic mis,
                         input logic e_ir, input logic e_dr, input logic e_en, input logic [31:0] e_ad,
                         input logic e_iv, input logic [31:0] e_id, input logic e_dv, input logic [31:0] e_dd,
                         input logic e_mis);
    check({s, "_i_req_ready"}, {31'h0, ir}, {31'h0, e_ir});
    check({s, "_d_req_ready"}, {31'h0, dr}, {31'h0, e_dr});
    check({s, "_rom_ena"},     {31'h0, en}, {31'h0, e_en});
    check({s, "_rom_addra"},   ad, e_ad);
    check({s, "_i_rsp_valid"}, {31'h0, iv}, {31'h0, e_iv});
    check({s, "_i_rsp_data"},  id, e_id);
    check({s, "_d_rsp_valid"}, {31'h0, dv}, {31'h0, e_dv});
    check({s, "_d_rsp_data"},  dd, e_dd);
    check({s, "_misalign"},    {31'h0, mis}, {31'h0, e_mis});
  endtask

  always @(negedge clka) begin
    logic        g, o;
    logic [31:0] a, e_ad;
    logic        e1iv, e1dv, e3iv, e3dv;
    logic [31:0] e1id, e1dd, e3id, e3dd;

    g    = !rsta && (i_req_valid || d_req_valid);
    o    = (i_req_valid && d_req_valid) ? !m_last : d_req_valid;
    a    = o ? d_req_addr : i_req_addr;
    e_ad = g ? {a[31:2], 2'b00} : 32'h0;

    e1iv = 1'b0; e1dv = 1'b0; e1id = 32'h0; e1dd = 32'h0;
    e3iv = 1'b0; e3dv = 1'b0; e3id = 32'h0; e3dd = 32'h0;
    if (!rsta && q1.size() > 0 && q1[0].due == cyc) begin
      if (q1[0].owner) begin e1dv = 1'b1; e1dd = q1[0].data; end
      else             begin e1iv = 1'b1; e1id = q1[0].data; end
    end
    if (!rsta && q3.size() > 0 && q3[0].due == cyc) begin
      if (q3[0].owner) begin e3dv = 1'b1; e3dd = q3[0].data; end
      else             begin e3iv = 1'b1; e3id = q3[0].data; end
    end

    if (m_live) begin
      cmp_dut("lat1", i_rdy1, d_rdy1, ena1, addra1, i_rv1, i_rd1, d_rv1, d_rd1, mis1,
              g && !o, g && o, g, e_ad, e1iv, e1id, e1dv, e1dd, m_mis);
      cmp_dut("lat3", i_rdy3, d_rdy3, ena3, addra3, i_rv3, i_rd3, d_rv3, d_rd3, mis3,
              g && !o, g && o, g, e_ad, e3iv, e3id, e3dv, e3dd, m_mis);
    end

    if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
    if (q3.size() > 0 && q3[0].due == cyc) void'(q3.pop_front());

    if (rsta) begin
      q1.delete();
      q3.delete();
      m_last  = 1'b1;
      m_mis   = 1'b0;
      m_live  = 1;
      m_i_acc = 0;
      m_d_acc = 0;
    end else begin
      m_i_acc = g && !o;
      m_d_acc = g && o;
      if (g) begin
        q1.push_back('{due: cyc + 1, owner: o, data: rom_word(a)});
        q3.push_back('{due: cyc + 3, owner: o, data: rom_word(a)});
        m_last = o;
        m_mis  = m_mis | (a[1:0] != 2'b00);
      end
    end
    cyc++;
  end

  // ---------------- stimulus with directed literal checks ----------------
  initial begin
    rsta        = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_addr = 32'h20;

    for (int j = 0; j < 3; j++) begin
      @(negedge clka);
      check("t1_i_req_ready", {31'h0, i_rdy1}, 32'h0);
      check("t1_d_req_ready", {31'h0, d_rdy1}, 32'h0);
      check("t1_rom_ena",     {31'h0, ena1},   32'h0);
      check("t1_rsp_valids",  {30'h0, i_rv1, d_rv1}, 32'h0);
      @(posedge clka); #1;
    end

    rsta = 1'b0; d_req_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      i_req_valid = (j < 4);
      i_req_addr  = 32'(4 * j);
      @(negedge clka);
      if (j < 4) check("t2_i_req_ready", {31'h0, i_rdy1}, 32'h1);
      if (j >= 1) begin
        check("t2_i_rsp_valid", {31'h0, i_rv1}, 32'h1);
        check("t2_i_rsp_data",  i_rd1, 32'hA500_0000 | 32'(j - 1));
      end
      check("t2_d_rsp_valid", {31'h0, d_rv1}, 32'h0);
      @(posedge clka); #1;
    end

    rsta = 1'b1; i_req_valid = 1'b0;
    @(posedge clka); #1;
    rsta = 1'b0;
    for (int j = 0; j < 5; j++) begin
      i_req_valid = (j < 4); i_req_addr = 32'h10;
      d_req_valid = (j < 4); d_req_addr = 32'h20;
      @(negedge clka);
      if (j < 4) begin
        check("t3_i_req_ready", {31'h0, i_rdy1}, (j % 2 == 0) ? 32'h1 : 32'h0);
        check("t3_d_req_ready", {31'h0, d_rdy1}, (j % 2 == 1) ? 32'h1 : 32'h0);
      end
      if (j >= 1) begin
        if ((j - 1) % 2 == 0) check("t3_i_rsp_data", i_rd1, 32'hA500_0004);
        else                  check("t3_d_rsp_data", d_rd1, 32'hA500_0008);
      end
      @(posedge clka); #1;
    end

    for (int j = 0; j < 4; j++) begin
      i_req_valid = 1'b0;
      d_req_valid = (j == 0); d_req_addr = 32'h0000_0006;
      @(negedge clka);
      if (j == 0) check("t4_rom_addra", addra1, 32'h4);
      if (j == 1) begin
        check("t4_d_rsp_data", d_rd1, 32'hA500_0001);
        check("t4_misalign",   {31'h0, mis1}, 32'h1);
      end
      if (j >= 2) check("t4_misalign_sticky", {31'h0, mis1}, 32'h1);
      @(posedge clka); #1;
    end
    d_req_valid = 1'b0;
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    @(negedge clka);
    check("t4_misalign_cleared", {31'h0, mis1}, 32'h0);
    @(posedge clka); #1;

    for (int j = 0; j < 6; j++) begin
      i_req_valid = (j == 0); i_req_addr = 32'h0;
      d_req_valid = (j == 1); d_req_addr = 32'h4;
      @(negedge clka);
      check("t5_i_rsp_valid", {31'h0, i_rv3}, (j == 3) ? 32'h1 : 32'h0);
      check("t5_d_rsp_valid", {31'h0, d_rv3}, (j == 4) ? 32'h1 : 32'h0);
      if (j == 3) check("t5_i_rsp_data", i_rd3, 32'hA500_0000);
      if (j == 4) check("t5_d_rsp_data", d_rd3, 32'hA500_0001);
      @(posedge clka); #1;
    end

    for (int j = 0; j < 7; j++) begin
      rsta        = (j == 1);
      i_req_valid = (j == 0); i_req_addr = 32'h8;
      d_req_valid = 1'b0;
      @(negedge clka);
      if (j == 0) check("t6_i_req_ready", {31'h0, i_rdy3}, 32'h1);
      if (j >= 2) check("t6_no_i_rsp", {31'h0, i_rv3}, 32'h0);
      @(posedge clka); #1;
    end

    for (int k = 0; k < 3000; k++) begin
      rsta = ($urandom_range(0, 63) == 0);
      if (!i_req_valid || m_i_acc) begin
        i_req_valid = ($urandom_range(0, 3) != 0);
        i_req_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 299) == 0) i_req_addr[1:0] = 2'($urandom_range(1, 3));
      end
      if (!d_req_valid || m_d_acc) begin
        d_req_valid = ($urandom_range(0, 3) != 0);
        d_req_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 299) == 0) d_req_addr[1:0] = 2'($urandom_range(1, 3));
      end
      @(posedge clka); #1;
    end

    @(negedge clka);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
